// File: rtl/tx_lane_serializer.sv
// NCH-channel word serializer on a single bit clock: captures one frame every NCH*W cycles
// and sends it MSB-first, channel 0 first. Optional scrambler via TX_SCRAMBLE_EN.
module tx_lane_serializer #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W = 8,
  parameter logic [W-1:0] IDLE_SYM = W'(8'hBC),
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned BW = $clog2(W)
) (
  input  logic              clk_32f,
  input  logic              rst,
  input  logic [NCH*W-1:0]  data_in,
  input  logic [NCH-1:0]    valid_in,
  input  logic              idle_in,
  output logic              salida_tx,
  output logic              frame_start,
  output logic              word_is_data,
  output logic [CW-1:0]     ch_active
);

  logic [BW-1:0]  bit_q, bit_d;
  logic [CW-1:0]  slot_q, slot_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   data_hold [NCH];
  logic [NCH-1:0] valid_hold;
  logic           idle_hold;
  logic           is_data_d;
  logic [CW-1:0]  ch_d;
  logic           start_d;
  logic           load, capture;
  logic [W-1:0]   cur_data;
  logic           cur_ok;

  // Channel 0 comes straight from the inputs on the capture edge; the rest from holding regs.
  always_comb begin
    bit_d     = bit_q;
    slot_d    = slot_q;
    shift_d   = {shift_q[W-2:0], 1'b0};
    is_data_d = word_is_data;
    ch_d      = ch_active;
    cur_data  = data_hold[slot_q];
    cur_ok    = valid_hold[slot_q] & ~idle_hold;
    load      = (bit_q == '0);
    capture   = load && (slot_q == '0);
    start_d   = capture;

    if (bit_q == BW'(W-1)) begin
      bit_d  = '0;
      slot_d = (slot_q == CW'(NCH-1)) ? '0 : slot_q + CW'(1);
    end else begin
      bit_d = bit_q + BW'(1);
    end

    if (slot_q == '0) begin
      cur_data = data_in[W-1:0];
      cur_ok   = valid_in[0] & ~idle_in;
    end

    if (load) begin
      shift_d   = cur_ok ? cur_data : IDLE_SYM;
      is_data_d = cur_ok;
      ch_d      = slot_q;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      bit_q        <= '0;
      slot_q       <= '0;
      shift_q      <= '0;
      valid_hold   <= '0;
      idle_hold    <= 1'b0;
      frame_start  <= 1'b0;
      word_is_data <= 1'b0;
      ch_active    <= '0;
      for (int unsigned c = 0; c < NCH; c++) data_hold[c] <= '0;
    end else begin
      bit_q        <= bit_d;
      slot_q       <= slot_d;
      shift_q      <= shift_d;
      frame_start  <= start_d;
      word_is_data <= is_data_d;
      ch_active    <= ch_d;
      if (capture) begin
        valid_hold <= valid_in;
        idle_hold  <= idle_in;
        for (int unsigned c = 0; c < NCH; c++) data_hold[c] <= data_in[c*W +: W];
      end
    end
  end

`ifdef TX_SCRAMBLE_EN
  logic [15:0] lfsr_q;
  logic        scr_q;

  // x^16+x^5+x^4+x^3+1; each shown bit uses the LFSR state held before that edge's step.
  always_ff @(posedge clk_32f) begin
    if (rst) begin
      lfsr_q <= 16'hFFFF;
      scr_q  <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2]};
      scr_q  <= shift_d[W-1] ^ (is_data_d & lfsr_q[15]);
    end
  end

  assign salida_tx = scr_q;
`else
  assign salida_tx = shift_q[W-1];
`endif

endmodule

// File: tb/tb_tx_lane_serializer.sv
// Scoreboard bench for tx_lane_serializer (NCH=4, W=8, IDLE 8'hBC).
module tb_tx_lane_serializer;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned FL  = NCH * W;
  localparam logic [7:0]  IDLE = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [3:0]  valid_in = '0;
  logic        idle_in = 1'b0;
  logic        salida_tx;
  logic        frame_start;
  logic        word_is_data;
  logic [1:0]  ch_active;

  tx_lane_serializer #(.NCH(NCH), .W(W), .IDLE_SYM(IDLE)) dut (
    .clk_32f(clk_32f), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .idle_in(idle_in), .salida_tx(salida_tx), .frame_start(frame_start),
    .word_is_data(word_is_data), .ch_active(ch_active)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic       bit_v;
    logic       start;
    logic       is_data;
    logic [1:0] ch;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] frame_bits = '0;
  logic [15:0] lfsr_m = 16'hFFFF;
  logic        mon_rst;
  exp_t        e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected frame: one entry per bit cycle, channel 0 first, MSB first.
  task automatic push_frame(input logic [31:0] d, input logic [3:0] v, input logic idl);
    for (int s = 0; s < NCH; s++) begin
      logic       ok;
      logic [7:0] word;
      ok   = v[s] && !idl;
      word = ok ? d[s*W +: W] : IDLE;
      for (int b = W - 1; b >= 0; b--) begin
        e.bit_v   = word[b];
        e.start   = (s == 0) && (b == W - 1);
        e.is_data = ok;
        e.ch      = 2'(s);
        sb.push_back(e);
      end
    end
  endtask

  // Called at the negedge before a capture edge; returns at the negedge before the next one.
  task automatic run_frame(input logic [31:0] d, input logic [3:0] v, input logic idl,
                           input logic mid, input logic [31:0] mid_d);
    data_in  = d;
    valid_in = v;
    idle_in  = idl;
    push_frame(d, v, idl);
    for (int k = 0; k < FL; k++) begin
      @(posedge clk_32f);
      @(negedge clk_32f);
      if (mid && k == 10) begin
        data_in  = mid_d;
        valid_in = ~valid_in;
        idle_in  = ~idle_in;
      end
    end
  endtask

  always @(posedge clk_32f) begin
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      sb.delete();
      lfsr_m = 16'hFFFF;
      check("reset_outputs", {27'd0, salida_tx, frame_start, word_is_data, ch_active}, 32'd0);
    end else if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      logic exp_bit;
      e = sb.pop_front();
      exp_bit = e.bit_v;
`ifdef TX_SCRAMBLE_EN
      exp_bit = exp_bit ^ (e.is_data & lfsr_m[15]);
      lfsr_m  = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[4] ^ lfsr_m[3] ^ lfsr_m[2]};
`endif
      check("serial_out", {27'd0, salida_tx, frame_start, word_is_data, ch_active},
            {27'd0, exp_bit, e.start, e.is_data, e.ch});
      frame_bits = {frame_bits[30:0], salida_tx};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    rst = 1'b0;

    run_frame(32'hFFBAFAFF, 4'hF, 1'b0, 1'b0, 32'h0);
`ifndef TX_SCRAMBLE_EN
    check("frame_all_valid", frame_bits, 32'hFFFABAFF);
`endif
    run_frame(32'hFFBAFAFF, 4'b0101, 1'b0, 1'b0, 32'h0);
`ifndef TX_SCRAMBLE_EN
    check("frame_valid_0101", frame_bits, 32'hFFBCBABC);
`endif
    run_frame(32'hFFBAFAFF, 4'hF, 1'b1, 1'b0, 32'h0);
    check("frame_idle", frame_bits, 32'hBCBCBCBC);
    run_frame(32'hFFBAFAFF, 4'hF, 1'b0, 1'b1, 32'h0);
`ifndef TX_SCRAMBLE_EN
    check("frame_mid_change", frame_bits, 32'hFFFABAFF);
`endif
    run_frame(32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
`ifndef TX_SCRAMBLE_EN
    check("frame_zero", frame_bits, 32'h00000000);
`endif

    // Reset 13 cycles into a frame; that frame is dropped.
    data_in  = $urandom;
    valid_in = 4'hF;
    idle_in  = 1'b0;
    push_frame(data_in, valid_in, idle_in);
    repeat (13) begin
      @(posedge clk_32f);
      @(negedge clk_32f);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    rst = 1'b0;
    run_frame(32'hA5C3_0FF0, 4'b1110, 1'b0, 1'b0, 32'h0);

    run_frame($urandom, 4'h0, 1'b0, 1'b0, 32'h0);
    check("frame_all_invalid", frame_bits, 32'hBCBCBCBC);

    repeat (20) begin
      run_frame($urandom, 4'($urandom), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), $urandom);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
